// File: rtl/gaussian_function_if.sv
// Chroma-in / likelihood-out bus for gaussian_function.
//   Cb, Cr     : 10-bit unsigned chroma samples, one pixel per clock
//   gauss_A    : 20-bit unsigned skin likelihood
//   skin_flag  : likelihood >= threshold (only with GAUSS_SKIN_FLAG_EN)
// master = pixel source / consumer, slave = gaussian_function.
interface gaussian_function_if;
  logic [9:0]  Cb;
  logic [9:0]  Cr;
  logic [19:0] gauss_A;
`ifdef GAUSS_SKIN_FLAG_EN
  logic        skin_flag;
  modport master (output Cb, Cr, input gauss_A, skin_flag);
  modport slave  (input Cb, Cr, output gauss_A, skin_flag);
`else
  modport master (output Cb, Cr, input gauss_A);
  modport slave  (input Cb, Cr, output gauss_A);
`endif
endinterface

// File: rtl/gaussian_function.sv
// Skin-colour likelihood: 2-D Gaussian in CbCr space, 4-stage pipeline,
// one pixel per clock, no handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every stage and outputs
//   bus   : gaussian_function_if.slave (Cb, Cr in; gauss_A out)
// Optional macro GAUSS_SKIN_FLAG_EN adds bus.skin_flag, registered with
// gauss_A, set when the likelihood is >= SKIN_THRESH.
// A sample on the bus at rising edge k appears on gauss_A after edge k+3.
module gaussian_function #(
  parameter int MEAN_CB     = 470,
  parameter int MEAN_CR     = 626,
  parameter int K_A         = 706,
  parameter int K_B         = -122,
  parameter int K_C         = 482,
  parameter int SKIN_THRESH = 524288
) (
  input logic            clk,
  input logic            rst_n,
  gaussian_function_if.slave bus
);

  localparam logic signed [10:0] M_CB = 11'(MEAN_CB);
  localparam logic signed [10:0] M_CR = 11'(MEAN_CR);
  localparam logic signed [34:0] KA   = 35'(K_A);
  localparam logic signed [34:0] KB2  = 35'(2 * K_B);
  localparam logic signed [34:0] KC   = 35'(K_C);

  // round(2^20 * e^(-i/32)), saturated to 20 bits (only i = 0 saturates).
  function automatic logic [19:0] rom_val(input int i);
    real v;
    v = 1048576.0 * $exp(-real'(i) / 32.0) + 0.5;
    if (v >= 1048575.0) return 20'hF_FFFF;
    return 20'($rtoi(v));
  endfunction

  logic [19:0] rom [512];
  for (genvar g = 0; g < 512; g++) begin : g_rom
    localparam logic [19:0] VAL = rom_val(g);
    assign rom[g] = VAL;
  end

  // stage 1: centred chroma
  logic signed [10:0] x_q, y_q;
  // stage 2: exact second-order terms
  logic signed [21:0] xx_q, yy_q, xy_q;
  // stage 3: clamped quadratic form, kept as D >> 16 (the ROM index range)
  logic [17:0] dsh_q;

  logic signed [34:0] d;
  logic [18:0] d_sh;
  logic        far;
  logic [19:0] g_next;

  always_comb begin
    d      = KA * 35'(xx_q) + KB2 * 35'(xy_q) + KC * 35'(yy_q);
    // arithmetic shift keeps the sign in bit 18 for the clamp
    d_sh   = 19'(d >>> 16);
    far    = |dsh_q[17:9];
    g_next = far ? 20'd0 : rom[dsh_q[8:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      xx_q        <= '0;
      yy_q        <= '0;
      xy_q        <= '0;
      dsh_q       <= '0;
      bus.gauss_A <= '0;
    end else begin
      x_q         <= $signed({1'b0, bus.Cb}) - M_CB;
      y_q         <= $signed({1'b0, bus.Cr}) - M_CR;
      xx_q        <= 22'(x_q) * 22'(x_q);
      yy_q        <= 22'(y_q) * 22'(y_q);
      xy_q        <= 22'(x_q) * 22'(y_q);
      dsh_q       <= d_sh[18] ? 18'd0 : d_sh[17:0];
      bus.gauss_A <= g_next;
    end
  end

`ifdef GAUSS_SKIN_FLAG_EN
  localparam logic [19:0] THR = 20'(SKIN_THRESH);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.skin_flag <= 1'b0;
    else        bus.skin_flag <= (g_next >= THR);
  end
`endif

endmodule

// File: tb/tb_gaussian_function.sv
module tb_gaussian_function;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int hist[$];
  logic [19:0] ga_pos, ga_neg;
  int diff;

  gaussian_function_if bus ();
  gaussian_function dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference: likelihood straight from the defining formula.
  function automatic int model(input int cb, input int cr);
    longint x, y, dd, i;
    real v;
    int r;
    x  = cb - 470;
    y  = cr - 626;
    dd = 706 * x * x + 2 * (-122) * x * y + 482 * y * y;
    if (dd < 0) dd = 0;
    i = dd / 65536;
    if (i >= 512) return 0;
    v = 1048576.0 * $exp(-real'(i) / 32.0);
    r = $rtoi(v + 0.5);
    if (r > 1048575) r = 1048575;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Called at a falling edge: drive one pixel, let one rising edge pass,
  // compare with the model of the pixel driven three edges earlier.
  task automatic cyc(input int cb, input int cr, input string tag);
    bus.Cb = 10'(cb);
    bus.Cr = 10'(cr);
    hist.push_back(model(cb, cr));
    @(posedge clk);
    #1;
    if (hist.size() >= 4) begin
      chk(tag, bus.gauss_A, 20'(hist[hist.size() - 4]));
`ifdef GAUSS_SKIN_FLAG_EN
      chk({tag, "_skin"}, {19'd0, bus.skin_flag},
          {19'd0, hist[hist.size() - 4] >= 524288});
`endif
    end
    @(negedge clk);
  endtask

  task automatic point(input int cb, input int cr, input string tag);
    for (int k = 0; k < 4; k++) cyc(cb, cr, tag);
  endtask

  initial begin
    bus.Cb = '0;
    bus.Cr = '0;
    // reset held with toggling inputs
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.Cb = 10'($urandom_range(0, 1023));
      bus.Cr = 10'($urandom_range(0, 1023));
      #1 chk("reset_hold", bus.gauss_A, 20'd0);
    end
    rst_n = 1'b1;

    point(470, 626, "mean_model");
    chk("mean", bus.gauss_A, 20'd1048575);
    point(502, 626, "offset_model");
    diff = int'(bus.gauss_A) - 743551;
    chk("offset_approx", 20'(diff >= -1 && diff <= 1), 20'd1);
    point(0, 0, "far_lo_model");
    chk("far_lo", bus.gauss_A, 20'd0);
    point(1023, 1023, "far_hi_model");
    chk("far_hi", bus.gauss_A, 20'd0);
    point(502, 658, "cross_pos_model");
    ga_pos = bus.gauss_A;
    point(502, 594, "cross_neg_model");
    ga_neg = bus.gauss_A;
    chk("cross_order", 20'(ga_pos > ga_neg), 20'd1);

    // back-to-back ramp with wrap, no bubbles
    for (int k = 0; k < 1100; k++) cyc(k % 1021, k % 1021, "stream");
    // random pixels
    for (int k = 0; k < 200; k++)
      cyc($urandom_range(0, 1023), $urandom_range(0, 1023), "random");
    // random pixels near the mean so the ROM body is exercised
    for (int k = 0; k < 200; k++)
      cyc($urandom_range(400, 540), $urandom_range(560, 690), "near_mean");

    // reset mid-stream: output must clear before the next rising edge
    #2 rst_n = 1'b0;
    #1 chk("async_reset", bus.gauss_A, 20'd0);
`ifdef GAUSS_SKIN_FLAG_EN
    chk("async_reset_skin", {19'd0, bus.skin_flag}, 20'd0);
`endif
    @(negedge clk);
    chk("reset_over_edge", bus.gauss_A, 20'd0);
    rst_n = 1'b1;
    hist.delete();
    for (int k = 0; k < 40; k++)
      cyc($urandom_range(420, 520), $urandom_range(580, 670), "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout observed=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
